// File: rtl/serial_logic_pkg.sv
// Shared types for the bit-serial mux-built logic unit.
package serial_logic_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_NAND = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bit-index counter width; a 1-bit unit still needs one counter bit.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/mux.sv
// 2:1 single-bit mux, the only primitive used by the logic datapath.
module mux (
    input  logic d0,
    input  logic d1,
    input  logic sel,
    output logic y
);

    assign y = sel ? d1 : d0;

endmodule

// File: rtl/mux_bit_op.sv
// One-bit AND/OR/XOR/NAND built purely from mux instances and constants.
module mux_bit_op (
    input  logic       a_bit,
    input  logic       b_bit,
    input  logic [1:0] op,
    output logic       y
);

    logic not_a;
    logic and_y;
    logic or_y;
    logic xor_y;
    logic nand_y;
    logic sel_lo;
    logic sel_hi;

    mux u_not_a (.d0(1'b1),  .d1(1'b0),   .sel(a_bit), .y(not_a));
    mux u_and   (.d0(1'b0),  .d1(a_bit),  .sel(b_bit), .y(and_y));
    mux u_or    (.d0(a_bit), .d1(1'b1),   .sel(b_bit), .y(or_y));
    mux u_xor   (.d0(a_bit), .d1(not_a),  .sel(b_bit), .y(xor_y));
    mux u_nand  (.d0(1'b1),  .d1(1'b0),   .sel(and_y), .y(nand_y));

    // op[0] picks within each pair, op[1] picks the pair
    mux u_sel_lo (.d0(and_y),  .d1(or_y),   .sel(op[0]), .y(sel_lo));
    mux u_sel_hi (.d0(xor_y),  .d1(nand_y), .sel(op[0]), .y(sel_hi));
    mux u_sel    (.d0(sel_lo), .d1(sel_hi), .sel(op[1]), .y(y));

endmodule

// File: rtl/serial_mux_logic_unit.sv
// Bit-serial two-operand logic unit, one result bit per clock, LSB first,
// with valid/ready handshakes on both sides.
//
// state | meaning
// IDLE  | waiting for an operand handshake
// RUN   | processing bit[cnt] each edge, result shifts in from the MSB
// DONE  | result held with out_valid until the consumer takes it
module serial_mux_logic_unit
    import serial_logic_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state;
    state_e           state_nx;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    op_e              op_sh;
    logic [CNT_W-1:0] cnt;
    logic             bit_y;
    logic             last;
    logic [WIDTH-1:0] shift_nx;

    mux_bit_op u_bit_op (
        .a_bit (a_sh[cnt]),
        .b_bit (b_sh[cnt]),
        .op    (op_sh),
        .y     (bit_y)
    );

    assign last = (cnt == CNT_LAST);
    assign busy = (state != IDLE);

    always_comb begin
        shift_nx = result >> 1;
        shift_nx[WIDTH-1] = bit_y;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid && in_ready) state_nx = RUN;
            RUN:     if (last) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            cnt       <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            op_sh     <= OP_AND;
        end else begin
            state    <= state_nx;
            in_ready <= (state_nx == IDLE);
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        op_sh <= op_e'(op);
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    result <= shift_nx;
                    // counter parks on the last index instead of wrapping
                    if (last) out_valid <= 1'b1;
                    else      cnt <= cnt + CNT_W'(1);
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
